// File: rtl/obstacle_manager_pkg.sv
// Shared game definitions used by the obstacle manager, AI controller and renderer.
package obstacle_manager_pkg;

    localparam int POS_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CRASHED = 2'd2
    } game_state_t;

    localparam logic OBST_CACTUS = 1'b0;
    localparam logic OBST_BIRD   = 1'b1;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as a mask over bits [15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/obstacle_manager_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; the seed is non-zero so it never locks up.
module lfsr16
    import obstacle_manager_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);

    // Seed on reset, otherwise step once per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= LFSR_SEED;
        end else begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/obstacle_manager.sv
// Spawns, scrolls and retires two obstacle slots; tracks score and scroll speed.
module obstacle_manager
    import obstacle_manager_pkg::*;
#(
    parameter int CONV        = 0,
    parameter int GEN_LINE    = 250,
    parameter int MIN_GAP     = 40,
    parameter int BASE_SPEED  = 1,
    parameter int MAX_SPEED   = 6,
    parameter int SPEED_SHIFT = 3
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic                  start,
    input  logic                  crash,
    output logic [POS_W-1:CONV]   obstacle1_pos,
    output logic [POS_W-1:CONV]   obstacle2_pos,
    output logic                  obstacle1_type,
    output logic                  obstacle2_type,
    output logic [9:0]            score,
    output logic                  running
);

    game_state_t      state_r;
    logic [POS_W-1:0] pos1_r, pos2_r;
    logic             type1_r, type2_r;
    logic [9:0]       score_r;
    logic [7:0]       timer_r;
    logic             running_r;

    logic [15:0]      lfsr_s;
    logic             lfsr_unused_s;

    logic             free1_s, free2_s, ret1_s, ret2_s;
    logic [9:0]       speed_sum_s;
    logic [3:0]       speed_s;
    logic [POS_W-1:0] speed_ext_s;
    logic [POS_W-1:0] pos1_nxt_s, pos2_nxt_s;
    logic             type1_nxt_s, type2_nxt_s;
    logic [7:0]       timer_nxt_s, reload_s;
    logic [9:0]       score_nxt_s;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_s)
    );

    assign lfsr_unused_s = ^lfsr_s[15:7];

    // Speed from the score held at tick start, saturated at MAX_SPEED.
    always_comb begin
        speed_sum_s = 10'(BASE_SPEED) + (score_r >> SPEED_SHIFT);
        if (speed_sum_s > 10'(MAX_SPEED)) begin
            speed_s = 4'(MAX_SPEED);
        end else begin
            speed_s = speed_sum_s[3:0];
        end
        speed_ext_s = {6'd0, speed_s};
    end

    // Per-tick slot movement, retirement and spawn decision.
    always_comb begin
        free1_s     = (pos1_r == 10'd0);
        free2_s     = (pos2_r == 10'd0);
        ret1_s      = !free1_s && (pos1_r <= speed_ext_s);
        ret2_s      = !free2_s && (pos2_r <= speed_ext_s);
        reload_s    = 8'(MIN_GAP) + {2'b00, lfsr_s[6:1]};
        type1_nxt_s = type1_r;
        type2_nxt_s = type2_r;
        timer_nxt_s = timer_r;
        score_nxt_s = score_r + {9'd0, ret1_s} + {9'd0, ret2_s};

        if (free1_s || ret1_s) begin
            pos1_nxt_s = 10'd0;
        end else begin
            pos1_nxt_s = pos1_r - speed_ext_s;
        end
        if (free2_s || ret2_s) begin
            pos2_nxt_s = 10'd0;
        end else begin
            pos2_nxt_s = pos2_r - speed_ext_s;
        end

        // Only slots free at tick start may take a spawn; a blocked spawn retries next tick.
        if (timer_r != 8'd0) begin
            timer_nxt_s = timer_r - 8'd1;
        end else if (free1_s) begin
            pos1_nxt_s  = 10'(GEN_LINE);
            type1_nxt_s = lfsr_s[0];
            timer_nxt_s = reload_s;
        end else if (free2_s) begin
            pos2_nxt_s  = 10'(GEN_LINE);
            type2_nxt_s = lfsr_s[0];
            timer_nxt_s = reload_s;
        end else begin
            timer_nxt_s = timer_r;
        end
    end

    // Game FSM and all registered game state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            pos1_r    <= 10'd0;
            pos2_r    <= 10'd0;
            type1_r   <= OBST_CACTUS;
            type2_r   <= OBST_CACTUS;
            score_r   <= 10'd0;
            timer_r   <= 8'(MIN_GAP);
            running_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (crash) begin
                        state_r   <= ST_CRASHED;
                        running_r <= 1'b0;
                    end else if (frame_tick) begin
                        pos1_r  <= pos1_nxt_s;
                        pos2_r  <= pos2_nxt_s;
                        type1_r <= type1_nxt_s;
                        type2_r <= type2_nxt_s;
                        score_r <= score_nxt_s;
                        timer_r <= timer_nxt_s;
                    end
                end
                ST_CRASHED: begin
                    if (start && !crash) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                        pos1_r    <= 10'd0;
                        pos2_r    <= 10'd0;
                        score_r   <= 10'd0;
                        timer_r   <= 8'(MIN_GAP);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    assign obstacle1_pos  = pos1_r[POS_W-1:CONV];
    assign obstacle2_pos  = pos2_r[POS_W-1:CONV];
    assign obstacle1_type = type1_r;
    assign obstacle2_type = type2_r;
    assign score          = score_r;
    assign running        = running_r;

endmodule

// File: tb/tb_obstacle_manager.sv
// Directed bench: default-parameter instance for spawn/crash/restart, short-parameter instance for speed scaling.
module tb_obstacle_manager;

    logic       clk;
    logic       rst;
    logic       ft_a, start_a, crash_a;
    logic [9:0] pos1_a, pos2_a, score_a;
    logic       type1_a, type2_a, running_a;
    logic       ft_b, start_b, crash_b;
    logic [9:0] pos1_b, pos2_b, score_b;
    logic       type1_b, type2_b, running_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] m_lfsr;
    logic [15:0] cap_lfsr;

    int m_p1, m_p2, m_t1, m_t2, m_score, m_timer;

    obstacle_manager dut_a (
        .clk(clk), .rst(rst), .frame_tick(ft_a), .start(start_a), .crash(crash_a),
        .obstacle1_pos(pos1_a), .obstacle2_pos(pos2_a),
        .obstacle1_type(type1_a), .obstacle2_type(type2_a),
        .score(score_a), .running(running_a)
    );

    obstacle_manager #(.GEN_LINE(20), .MIN_GAP(2)) dut_b (
        .clk(clk), .rst(rst), .frame_tick(ft_b), .start(start_b), .crash(crash_b),
        .obstacle1_pos(pos1_b), .obstacle2_pos(pos2_b),
        .obstacle1_type(type1_b), .obstacle2_type(type2_b),
        .score(score_b), .running(running_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: taps 16,14,13,11, shifting left.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One frame tick on instance a (sel=0) or b (sel=1); outputs are valid on return.
    task automatic tick(input bit sel);
        if (sel) ft_b = 1'b1;
        else     ft_a = 1'b1;
        cap_lfsr = m_lfsr;
        @(posedge clk); #1;
        ft_a = 1'b0;
        ft_b = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Tick-level model of instance b (GEN_LINE 20, MIN_GAP 2).
    task automatic model_b_step(input logic [15:0] l);
        int sp;
        bit f1, f2;
        sp = 1 + (m_score >> 3);
        if (sp > 6) sp = 6;
        f1 = (m_p1 == 0);
        f2 = (m_p2 == 0);
        if (!f1) begin
            if (m_p1 <= sp) begin m_p1 = 0; m_score = m_score + 1; end
            else m_p1 = m_p1 - sp;
        end
        if (!f2) begin
            if (m_p2 <= sp) begin m_p2 = 0; m_score = m_score + 1; end
            else m_p2 = m_p2 - sp;
        end
        if (m_timer != 0) m_timer = m_timer - 1;
        else if (f1) begin m_p1 = 20; m_t1 = int'(l[0]); m_timer = 2 + int'(l[6:1]); end
        else if (f2) begin m_p2 = 20; m_t2 = int'(l[0]); m_timer = 2 + int'(l[6:1]); end
    endtask

    initial begin
        int r1;
        int pb1, pb2, sb;
        bit seen4, seen6;
        int guard;

        rst = 1'b1;
        ft_a = 1'b0; start_a = 1'b0; crash_a = 1'b0;
        ft_b = 1'b0; start_b = 1'b0; crash_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_eq("rst_running", running_a, 0);
        check_eq("rst_pos1", pos1_a, 0);
        check_eq("rst_pos2", pos2_a, 0);
        check_eq("rst_score", score_a, 0);
        check_eq("rst_type1", type1_a, 0);

        pulse_start(1'b0);
        check_eq("start_running", running_a, 1);
        check_eq("start_pos1", pos1_a, 0);
        check_eq("start_score", score_a, 0);

        repeat (40) tick(1'b0);
        check_eq("gap40_pos1", pos1_a, 0);
        tick(1'b0);
        check_eq("spawn_pos1", pos1_a, 250);
        check_eq("spawn_type1", type1_a, int'(cap_lfsr[0]));
        check_eq("spawn_pos2", pos2_a, 0);
        r1 = int'(cap_lfsr[6:1]);

        // Second slot spawns 41+r1 ticks after the first.
        repeat (248) tick(1'b0);
        check_eq("slide_pos1_2", pos1_a, 2);
        check_eq("slide_pos2", pos2_a, 43 + r1);
        check_eq("slide_score", score_a, 0);
        tick(1'b0);
        check_eq("slide_pos1_1", pos1_a, 1);
        tick(1'b0);
        check_eq("retire_pos1", pos1_a, 0);
        check_eq("retire_score", score_a, 1);
        check_eq("blocked_pos2", pos2_a, 41 + r1);
        tick(1'b0);
        check_eq("respawn_pos1", pos1_a, 250);
        check_eq("respawn_type1", type1_a, int'(cap_lfsr[0]));

        pulse_start(1'b0);
        check_eq("start_in_run_pos1", pos1_a, 250);
        check_eq("start_in_run_score", score_a, 1);

        repeat (150) tick(1'b0);
        check_eq("pre_crash_pos1", pos1_a, 100);
        check_eq("pre_crash_score", score_a, 2);

        crash_a = 1'b1;
        ft_a = 1'b1;
        @(posedge clk); #1;
        crash_a = 1'b0;
        ft_a = 1'b0;
        check_eq("crash_pos1", pos1_a, 100);
        check_eq("crash_running", running_a, 0);
        check_eq("crash_score", score_a, 2);
        repeat (5) tick(1'b0);
        check_eq("frozen_pos1", pos1_a, 100);
        check_eq("frozen_score", score_a, 2);

        pulse_start(1'b0);
        check_eq("restart_pos1", pos1_a, 0);
        check_eq("restart_pos2", pos2_a, 0);
        check_eq("restart_score", score_a, 0);
        check_eq("restart_running", running_a, 1);
        repeat (40) tick(1'b0);
        check_eq("restart_gap_pos1", pos1_a, 0);
        tick(1'b0);
        check_eq("restart_spawn_pos1", pos1_a, 250);
        check_eq("restart_spawn_type1", type1_a, int'(cap_lfsr[0]));

        // Instance b: ticks ignored while idle, then track the model.
        repeat (3) tick(1'b1);
        check_eq("idle_pos1_b", pos1_b, 0);
        check_eq("idle_running_b", running_b, 0);
        pulse_start(1'b1);
        check_eq("start_running_b", running_b, 1);
        m_p1 = 0; m_p2 = 0; m_t1 = 0; m_t2 = 0; m_score = 0; m_timer = 2;
        seen4 = 1'b0;
        seen6 = 1'b0;
        guard = 0;
        while (!(m_score >= 52 && seen4 && seen6) && guard < 8000) begin
            pb1 = m_p1;
            pb2 = m_p2;
            sb  = m_score;
            tick(1'b1);
            model_b_step(cap_lfsr);
            guard++;
            check_eq("b_pos1", pos1_b, m_p1);
            check_eq("b_pos2", pos2_b, m_p2);
            check_eq("b_score", score_b, m_score);
            check_eq("b_type1", type1_b, m_t1);
            check_eq("b_type2", type2_b, m_t2);
            if (!seen4 && sb >= 24 && sb <= 31 && pb1 > 4) begin
                check_eq("speed4_step", pb1 - int'(pos1_b), 4);
                seen4 = 1'b1;
            end
            if (!seen6 && sb >= 48 && pb2 > 6) begin
                check_eq("speed6_step", pb2 - int'(pos2_b), 6);
                seen6 = 1'b1;
            end
        end
        check_eq("speed4_seen", int'(seen4), 1);
        check_eq("speed6_seen", int'(seen6), 1);

        // Reset while running returns to idle with reset values.
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_running", running_a, 0);
        check_eq("midrst_pos1", pos1_a, 0);
        check_eq("midrst_score_b", score_b, 0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
